// File: rtl/adc0809_seq_pkg.sv
// Shared types, widths and default timing for the ADC0809 conversion sequencer.
package adc0809_seq_pkg;

   localparam int ADC_CH_W = 3;
   localparam int ADC_D_W  = 8;

   localparam int DEF_CLK_DIV      = 50;
   localparam int DEF_PULSE_W      = 4;
   localparam int DEF_EOC_LOW_MAX  = 1023;
   localparam int DEF_EOC_HIGH_MAX = 65535;

   typedef enum logic [2:0] {
      IDLE, SETUP, STROBE, WAIT_LO, WAIT_HI, READ, NEXT, ABORT
   } state_t;

   // Bits needed to hold 0..max, never less than one.
   function automatic int cnt_width(input int max);
      return (max < 2) ? 1 : $clog2(max + 1);
   endfunction

endpackage

// File: rtl/adc0809_seq_clkdiv.sv
// Free-running converter clock divider: adc_clk toggles every CLK_DIV system clocks.
module adc_clkdiv
   import adc0809_seq_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   output logic adc_clk
);

   localparam int CW = cnt_width(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         adc_clk <= 1'b0;
      end else if (cnt == CW'(CLK_DIV - 1)) begin
         cnt     <= '0;
         adc_clk <= ~adc_clk;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/adc0809_seq.sv
// ADC0809 sequencer: address/ALE/START strobing, EOC handshake with timeouts,
// OE read-out and result capture for single conversions and channel scans.
module adc0809_seq
   import adc0809_seq_pkg::*;
#(
   parameter int CLK_DIV      = DEF_CLK_DIV,
   parameter int PULSE_W      = DEF_PULSE_W,
   parameter int EOC_LOW_MAX  = DEF_EOC_LOW_MAX,
   parameter int EOC_HIGH_MAX = DEF_EOC_HIGH_MAX
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                go,
   input  logic [ADC_CH_W-1:0] chan,
   input  logic                scan_en,
   input  logic [ADC_CH_W-1:0] scan_last,
   input  logic                eoc,
   input  logic [ADC_D_W-1:0]  adc_d,
   output logic                adc_clk,
   output logic [ADC_CH_W-1:0] addr,
   output logic                ale,
   output logic                start,
   output logic                oe,
   output logic [ADC_D_W-1:0]  data,
   output logic [ADC_CH_W-1:0] data_chan,
   output logic                valid,
   output logic                busy,
   output logic                irq,
   output logic                timeout
);

   localparam int WAIT_MAX = (EOC_HIGH_MAX > EOC_LOW_MAX) ? EOC_HIGH_MAX : EOC_LOW_MAX;
   localparam int CNT_MAX  = (WAIT_MAX > PULSE_W) ? WAIT_MAX : PULSE_W;
   localparam int CW       = cnt_width(CNT_MAX);

   state_t              state, state_d;
   logic [CW-1:0]       cnt;
   logic [ADC_CH_W-1:0] cur, last_q;
   logic                scan_q;
   logic                eoc_m, eoc_s;
   logic                more, to_hit, cap;

   adc_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
      .clk     (clk),
      .rst     (rst),
      .adc_clk (adc_clk)
   );

   // Idle level of EOC is high, so the synchronizer resets to 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         eoc_m <= 1'b1;
         eoc_s <= 1'b1;
      end else begin
         eoc_m <= eoc;
         eoc_s <= eoc_m;
      end
   end

   assign more = scan_q && (cur != last_q);

   always_comb begin
      state_d = state;
      to_hit  = 1'b0;
      case (state)
         IDLE:    if (go) state_d = SETUP;
         SETUP:   state_d = STROBE;
         STROBE:  if (cnt == CW'(PULSE_W - 1)) state_d = WAIT_LO;
         WAIT_LO: begin
            if (!eoc_s) state_d = WAIT_HI;
            else if (cnt == CW'(EOC_LOW_MAX - 1)) begin
               to_hit  = 1'b1;
               state_d = ABORT;
            end
         end
         WAIT_HI: begin
            if (eoc_s) state_d = READ;
            else if (cnt == CW'(EOC_HIGH_MAX - 1)) begin
               to_hit  = 1'b1;
               state_d = ABORT;
            end
         end
         // READ holds one extra cycle past the OE pulse so valid lands before NEXT.
         READ:    if (cnt == CW'(PULSE_W)) state_d = NEXT;
         NEXT:    state_d = more ? SETUP : IDLE;
         ABORT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ale   = (state == STROBE);
   assign start = (state == STROBE);
   assign oe    = (state == READ) && (cnt < CW'(PULSE_W));
   assign cap   = (state == READ) && (cnt == CW'(PULSE_W - 1));
   assign busy  = (state != IDLE);
   assign irq   = ((state == NEXT) && !more) || (state == ABORT);
   assign addr  = cur;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         cur       <= '0;
         last_q    <= '0;
         scan_q    <= 1'b0;
         data      <= '0;
         data_chan <= '0;
         valid     <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= ((state_d != state) || (state == IDLE)) ? '0 : cnt + CW'(1);
         valid <= cap;
         if (cap) begin
            data      <= adc_d;
            data_chan <= cur;
         end
         if (to_hit) timeout <= 1'b1;
         if ((state == IDLE) && go) begin
            cur     <= chan;
            scan_q  <= scan_en;
            last_q  <= scan_last;
            timeout <= 1'b0;
         end
         if ((state == NEXT) && more) cur <= cur + ADC_CH_W'(1);
      end
   end

endmodule

// File: tb/tb_adc0809_seq.sv
// Directed bench for adc0809_seq: table of conversions/scans against an EOC/data
// converter model, plus hand sequences for busy-go, reset-in-READ and adc_clk.
module tb_adc0809_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       go = 1'b0;
   logic [2:0] chan = '0;
   logic       scan_en = 1'b0;
   logic [2:0] scan_last = '0;
   logic       eoc;
   logic [7:0] adc_d;
   logic       adc_clk, ale, start, oe, valid, busy, irq, timeout;
   logic [2:0] addr, data_chan;
   logic [7:0] data;

   int checks = 0;
   int errors = 0;

   adc0809_seq #(
      .CLK_DIV      (3),
      .PULSE_W      (4),
      .EOC_LOW_MAX  (1023),
      .EOC_HIGH_MAX (65535)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .go        (go),
      .chan      (chan),
      .scan_en   (scan_en),
      .scan_last (scan_last),
      .eoc       (eoc),
      .adc_d     (adc_d),
      .adc_clk   (adc_clk),
      .addr      (addr),
      .ale       (ale),
      .start     (start),
      .oe        (oe),
      .data      (data),
      .data_chan (data_chan),
      .valid     (valid),
      .busy      (busy),
      .irq       (irq),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   // Converter model: latches the mux address on ALE, drives base+channel while OE.
   int         m_fall = 10;
   int         m_rise = 200;
   bit         m_nofall = 1'b1;
   logic [7:0] m_base = '0;
   logic [2:0] lat_addr = '0;

   always @(posedge ale) lat_addr = addr;
   assign adc_d = oe ? (m_base + {5'd0, lat_addr}) : 8'h00;

   initial begin
      eoc = 1'b1;
      forever begin
         @(negedge start);
         if (!m_nofall) begin
            repeat (m_fall) @(posedge clk);
            #1 eoc = 1'b0;
            repeat (m_rise) @(posedge clk);
            #1 eoc = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [2:0]       chan;
      logic             scan;
      logic [2:0]       last;
      int               fall;
      int               rise;
      bit               nofall;
      logic [7:0]       base;
      int               n;
      logic [0:3][7:0]  d;
      logic [0:3][2:0]  ch;
      bit               to;
   } vec_t;

   vec_t vec [5];

   task automatic run_txn(input int idx, input vec_t v);
      int n_v = 0, n_irq = 0, n_ale = 0, n_oe = 0, n_bad = 0;
      int irq_c = -1, val_c = -1, sf_c = -1, k = 0, nconv;
      logic sprev = 1'b0;
      logic [0:3][7:0] gd = '0;
      logic [0:3][2:0] gc = '0;
      m_fall = v.fall; m_rise = v.rise; m_nofall = v.nofall; m_base = v.base;
      @(negedge clk);
      chan = v.chan; scan_en = v.scan; scan_last = v.last; go = 1'b1;
      @(negedge clk);
      go = 1'b0; chan = '0; scan_en = 1'b0; scan_last = '0;
      chk($sformatf("v%0d_busy_after_go", idx), busy, 1);
      chk($sformatf("v%0d_timeout_cleared", idx), timeout, 0);
      while (busy && k < 5000) begin
         if (ale) n_ale++;
         if (oe) n_oe++;
         if (ale !== start) n_bad++;
         if (valid && irq) n_bad++;
         if (valid) begin
            if (n_v < 4) begin gd[n_v] = data; gc[n_v] = data_chan; end
            n_v++; val_c = k;
         end
         if (irq) begin n_irq++; irq_c = k; end
         if (sprev && !start) sf_c = k;
         sprev = start;
         @(negedge clk); k++;
      end
      chk($sformatf("v%0d_done_in_budget", idx), busy, 0);
      nconv = v.nofall ? 1 : v.n;
      chk($sformatf("v%0d_valid_count", idx), n_v, v.n);
      for (int i = 0; i < v.n; i++) begin
         chk($sformatf("v%0d_data%0d", idx, i), gd[i], v.d[i]);
         chk($sformatf("v%0d_chan%0d", idx, i), gc[i], v.ch[i]);
      end
      chk($sformatf("v%0d_irq_count", idx), n_irq, 1);
      chk($sformatf("v%0d_ale_cycles", idx), n_ale, 4 * nconv);
      chk($sformatf("v%0d_oe_cycles", idx), n_oe, 4 * v.n);
      chk($sformatf("v%0d_strobe_overlap_errs", idx), n_bad, 0);
      chk($sformatf("v%0d_timeout", idx), timeout, v.to);
      if (v.n > 0) chk($sformatf("v%0d_irq_after_valid", idx), irq_c - val_c, 1);
      if (v.nofall) chk($sformatf("v%0d_timeout_delay", idx), irq_c - sf_c, 1023);
   endtask

   initial begin
      int n_v, n_irq, n_busy, k, ntog, first_tog, last_tog, bad_iv;
      logic prev;

      vec[0] = '{chan:3'd5, scan:1'b0, last:3'd0, fall:10, rise:200, nofall:1'b0, base:8'hA0,
                 n:1, d:{8'hA5, 8'h00, 8'h00, 8'h00}, ch:{3'd5, 3'd0, 3'd0, 3'd0}, to:1'b0};
      vec[1] = '{chan:3'd6, scan:1'b1, last:3'd1, fall:10, rise:50, nofall:1'b0, base:8'h10,
                 n:4, d:{8'h16, 8'h17, 8'h10, 8'h11}, ch:{3'd6, 3'd7, 3'd0, 3'd1}, to:1'b0};
      vec[2] = '{chan:3'd2, scan:1'b0, last:3'd0, fall:0, rise:0, nofall:1'b1, base:8'h00,
                 n:0, d:'0, ch:'0, to:1'b1};
      vec[3] = '{chan:3'd3, scan:1'b1, last:3'd3, fall:5, rise:30, nofall:1'b0, base:8'h40,
                 n:1, d:{8'h43, 8'h00, 8'h00, 8'h00}, ch:{3'd3, 3'd0, 3'd0, 3'd0}, to:1'b0};
      vec[4] = '{chan:3'd0, scan:1'b1, last:3'd2, fall:1, rise:1, nofall:1'b0, base:8'h20,
                 n:3, d:{8'h20, 8'h21, 8'h22, 8'h00}, ch:{3'd0, 3'd1, 3'd2, 3'd0}, to:1'b0};

      // Reset values.
      repeat (5) @(negedge clk);
      chk("rst_adc_clk", adc_clk, 0);
      chk("rst_strobes", {ale, start, oe, valid, irq, busy, timeout}, 7'b0);
      chk("rst_addr", addr, 0);
      chk("rst_data", {data, data_chan}, 11'd0);

      // adc_clk with CLK_DIV=3 across reset release and idle: toggle every 3 clocks.
      rst = 1'b0;
      prev = 1'b0; ntog = 0; first_tog = -1; last_tog = -1; bad_iv = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (adc_clk !== prev) begin
            if (first_tog < 0) first_tog = i;
            else if (i - last_tog != 3) bad_iv++;
            last_tog = i; ntog++;
         end
         prev = adc_clk;
      end
      chk("clkdiv_first_toggle", first_tog, 2);
      chk("clkdiv_toggles", ntog, 10);
      chk("clkdiv_bad_intervals", bad_iv, 0);

      for (int i = 0; i < 5; i++) run_txn(i, vec[i]);

      // go while busy (in WAIT_HI) must be ignored.
      m_fall = 5; m_rise = 100; m_nofall = 1'b0; m_base = 8'h30;
      @(negedge clk);
      chan = 3'd2; scan_en = 1'b0; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      k = 0;
      while (eoc && k < 300) begin @(negedge clk); k++; end
      chk("busygo_eoc_fell", eoc, 0);
      repeat (6) @(negedge clk);
      chan = 3'd7; scan_en = 1'b1; scan_last = 3'd7; go = 1'b1;
      @(negedge clk);
      go = 1'b0; scan_en = 1'b0;
      n_v = 0; n_irq = 0; k = 0;
      while (busy && k < 2000) begin
         if (valid) n_v++;
         if (irq) n_irq++;
         @(negedge clk); k++;
      end
      chk("busygo_valid_count", n_v, 1);
      chk("busygo_irq_count", n_irq, 1);
      chk("busygo_data", data, 8'h32);
      chk("busygo_data_chan", data_chan, 2);
      n_busy = 0;
      for (int i = 0; i < 20; i++) begin @(negedge clk); if (busy) n_busy++; end
      chk("busygo_no_requeue", n_busy, 0);

      // Reset during READ with oe high.
      m_fall = 3; m_rise = 20; m_nofall = 1'b0; m_base = 8'h50;
      @(negedge clk);
      chan = 3'd4; scan_en = 1'b0; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      k = 0;
      while (!oe && k < 500) begin @(negedge clk); k++; end
      chk("rstread_oe_seen", oe, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rstread_oe", oe, 0);
      chk("rstread_busy", busy, 0);
      chk("rstread_valid", valid, 0);
      chk("rstread_data", data, 0);
      chk("rstread_addr", addr, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      run_txn(5, vec[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
